irin_keyq: RTL and testbench

IRIN_KEYQ -- requirements
Module: irin_keyq

---
 rtl/irin_keyq_if.sv | 24 ++
 rtl/irin_keyq.sv | 208 ++++++++++++++++++++
 tb/tb_irin_keyq.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irin_keyq_if.sv
// Bus between an NEC frame decoder/consumer and the key-event queue.
// The master side drives decoded frames and pops events; the slave side is the queue.
interface irin_keyq_if;
  logic        frame_valid;
  logic [31:0] frame;
  logic        repeat_valid;
  logic        out_ready;
  logic        out_valid;
  logic [8:0]  out_data;
  logic        key_down;
  logic [7:0]  key_code;
  logic [7:0]  err_count;
  logic        overflow;

  modport master (
    output frame_valid, frame, repeat_valid, out_ready,
    input  out_valid, out_data, key_down, key_code, err_count, overflow
  );

  modport slave (
    input  frame_valid, frame, repeat_valid, out_ready,
    output out_valid, out_data, key_down, key_code, err_count, overflow
  );
endinterface

// File: rtl/irin_keyq.sv
// NEC remote key tracker: turns decoded frames and repeat codes into press/release
// events with a hold timeout, queued in a 4-entry FIFO.
module irin_keyq #(
  parameter int unsigned TICK_DIV   = 48000,
  parameter int unsigned HOLD_MS    = 120,
  parameter bit          ADDR_CHECK = 1'b0,
  parameter logic [7:0]  ADDR       = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  irin_keyq_if.slave bus
);

  localparam int unsigned   PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [15:0]   HOLD_LD  = 16'(HOLD_MS);
  localparam int unsigned   DEPTH    = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HELD = 2'd1,
    S_SWAP = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Input stage: also makes the first action after reset land on the second edge
  // ---------------------------------------------------------------------------
  logic        fv_q;
  logic        rv_q;
  logic [31:0] frame_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fv_q    <= 1'b0;
      rv_q    <= 1'b0;
      frame_q <= '0;
    end else begin
      fv_q    <= bus.frame_valid;
      rv_q    <= bus.repeat_valid;
      frame_q <= bus.frame;
    end
  end

  logic [7:0] cmd;
  logic       cmd_ok;
  logic       addr_ok;
  logic       frame_ok;

  assign cmd      = frame_q[23:16];
  assign cmd_ok   = (frame_q[31:24] == ~frame_q[23:16]);
  assign addr_ok  = (frame_q[7:0] == ADDR) && (frame_q[15:8] == ~ADDR);
  assign frame_ok = cmd_ok && (!ADDR_CHECK || addr_ok);

  // ---------------------------------------------------------------------------
  // Millisecond prescaler, restarted whenever the hold timer is reloaded
  // ---------------------------------------------------------------------------
  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;
  logic          tick;
  logic          reload;

  assign tick  = (pre_q == PRE_LAST);
  assign pre_d = (reload || tick) ? '0 : pre_q + PW'(1);

  // ---------------------------------------------------------------------------
  // Key state machine
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  key_q, key_d;
  logic [7:0]  new_q, new_d;
  logic        push;
  logic [8:0]  push_data;
  logic        err_inc;

  // A frame arriving mid-swap is rejected even if it is well-formed.
  assign err_inc = fv_q && (!frame_ok || (state_q == S_SWAP));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d   = state_q;
    timer_d   = timer_q;
    key_d     = key_q;
    new_d     = new_q;
    push      = 1'b0;
    push_data = '0;
    reload    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fv_q && frame_ok) begin
          push      = 1'b1;
          push_data = {1'b1, cmd};
          key_d     = cmd;
          reload    = 1'b1;
          state_d   = S_HELD;
        end
      end
      S_HELD: begin
        if (fv_q && frame_ok) begin
          if (cmd == key_q) begin
            reload = 1'b1;
          end else begin
            push      = 1'b1;
            push_data = {1'b0, key_q};
            new_d     = cmd;
            state_d   = S_SWAP;
          end
        end else if (rv_q && !fv_q) begin
          reload = 1'b1;
        end else if (tick) begin
          timer_d = timer_q - 16'd1;
          if (timer_q <= 16'd1) begin
            push      = 1'b1;
            push_data = {1'b0, key_q};
            timer_d   = '0;
            state_d   = S_IDLE;
          end
        end
      end
      S_SWAP: begin
        push      = 1'b1;
        push_data = {1'b1, new_q};
        key_d     = new_q;
        reload    = 1'b1;
        state_d   = S_HELD;
      end
      default: state_d = S_IDLE;
    endcase

    if (reload) timer_d = HOLD_LD;
  end

  logic [7:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      pre_q   <= '0;
      key_q   <= '0;
      new_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pre_q   <= pre_d;
      key_q   <= key_d;
      new_q   <= new_d;
      if (err_inc && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------------
  logic [8:0] mem_q [DEPTH];
  logic [1:0] wr_ptr_q;
  logic [1:0] rd_ptr_q;
  logic [2:0] count_q;
  logic [8:0] last_q;
  logic       ovf_q;
  logic       empty;
  logic       full;
  logic       pop;
  logic       push_ok;

  assign empty   = (count_q == 3'd0);
  assign full    = (count_q == 3'(DEPTH));
  assign pop     = !empty && bus.out_ready;
  assign push_ok = push && (!full || pop);

  // NOTE: storage is deliberately not reset; an entry is only read after it has
  // been written, and the count/pointers carry the reset state.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
        last_q   <= mem_q[rd_ptr_q];
      end
      count_q <= count_q + 3'(push_ok) - 3'(pop);
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  // When empty, the last popped event stays visible on out_data.
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? last_q : mem_q[rd_ptr_q];
  assign bus.key_down  = (state_q != S_IDLE);
  assign bus.key_code  = key_q;
  assign bus.err_count = err_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_irin_keyq.sv
// Bench for irin_keyq: event-level reference model checked every cycle, plus
// directed sequences with hand-computed expectations.
module tb_irin_keyq;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned HOLD_MS  = 3;
  localparam longint      HOLD_CYC = longint'(TICK_DIV * HOLD_MS);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  irin_keyq_if bus();

  irin_keyq #(
    .TICK_DIV  (TICK_DIV),
    .HOLD_MS   (HOLD_MS),
    .ADDR_CHECK(1'b1),
    .ADDR      (8'h00)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: events as a queue, hold timeout as an absolute deadline
  // ---------------------------------------------------------------------------
  typedef enum {M_IDLE, M_HELD, M_SWAP} mstate_e;

  mstate_e     m_state;
  logic [7:0]  m_key, m_new, m_err;
  bit          m_ovf;
  logic [8:0]  m_last;
  logic [8:0]  m_q[$];
  longint      cyc = 0;
  longint      m_deadline;
  bit          s_fv, s_rv;
  logic [31:0] s_frame;

  task automatic model_reset();
    m_state = M_IDLE;
    m_key = 8'h00; m_new = 8'h00; m_err = 8'h00;
    m_ovf = 1'b0; m_last = 9'h000;
    m_q.delete();
    m_deadline = -1;
    s_fv = 1'b0; s_rv = 1'b0; s_frame = '0;
  endtask

  // One clock edge: act on the inputs captured at the previous edge.
  task automatic model_edge();
    bit         ok, pop, do_push, push_ok;
    logic [8:0] pd;
    logic [7:0] c;
    cyc++;
    do_push = 1'b0;
    pd = '0;
    c  = s_frame[23:16];
    ok = (s_frame[31:24] == ~s_frame[23:16]) && (s_frame[7:0] == 8'h00) && (s_frame[15:8] == 8'hFF);
    if (s_fv && (!ok || m_state == M_SWAP) && m_err != 8'hFF) m_err++;
    case (m_state)
      M_IDLE: if (s_fv && ok) begin
        do_push = 1'b1; pd = {1'b1, c}; m_key = c;
        m_deadline = cyc + HOLD_CYC; m_state = M_HELD;
      end
      M_HELD: begin
        if (s_fv && ok) begin
          if (c == m_key) m_deadline = cyc + HOLD_CYC;
          else begin
            do_push = 1'b1; pd = {1'b0, m_key}; m_new = c; m_state = M_SWAP;
          end
        end else if (s_rv && !s_fv) begin
          m_deadline = cyc + HOLD_CYC;
        end else if (cyc == m_deadline) begin
          do_push = 1'b1; pd = {1'b0, m_key}; m_state = M_IDLE;
        end
      end
      M_SWAP: begin
        do_push = 1'b1; pd = {1'b1, m_new}; m_key = m_new;
        m_deadline = cyc + HOLD_CYC; m_state = M_HELD;
      end
      default: ;
    endcase
    pop     = bus.out_ready && (m_q.size() > 0);
    push_ok = do_push && !(m_q.size() == 4 && !pop);
    if (do_push && !push_ok) m_ovf = 1'b1;
    if (pop) m_last = m_q.pop_front();
    if (push_ok) m_q.push_back(pd);
    s_fv    = bus.frame_valid;
    s_rv    = bus.repeat_valid;
    s_frame = bus.frame;
  endtask

  // Compare process: every cycle, 1 time unit after the rising edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) model_reset();
      else begin
        model_edge();
        check("cyc_out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
        check("cyc_out_data",  32'(bus.out_data),  32'((m_q.size() != 0) ? m_q[0] : m_last));
        check("cyc_key_down",  32'(bus.key_down),  32'(m_state != M_IDLE));
        check("cyc_key_code",  32'(bus.key_code),  32'(m_key));
        check("cyc_err_count", 32'(bus.err_count), 32'(m_err));
        check("cyc_overflow",  32'(bus.overflow),  32'(m_ovf));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at a falling edge, return at a falling edge)
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] nec(input logic [7:0] a, input logic [7:0] c);
    return {~c, c, ~a, a};
  endfunction

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_frame(input logic [31:0] f);
    bus.frame_valid = 1'b1;
    bus.frame       = f;
    @(negedge clk);
    bus.frame_valid = 1'b0;
  endtask

  task automatic pulse_repeat();
    bus.repeat_valid = 1'b1;
    @(negedge clk);
    bus.repeat_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wait_n(2);
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_data"},  32'(bus.out_data),  32'd0);
    check({tag, "_key_down"},  32'(bus.key_down),  32'd0);
    check({tag, "_key_code"},  32'(bus.key_code),  32'd0);
    check({tag, "_err_count"}, 32'(bus.err_count), 32'd0);
    check({tag, "_overflow"},  32'(bus.overflow),  32'd0);
  endtask

  logic [8:0] drain_exp [4];

  initial begin
    bus.frame_valid  = 1'b0;
    bus.frame        = '0;
    bus.repeat_valid = 1'b0;
    bus.out_ready    = 1'b1;
    wait_n(3);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Single press then timeout; frame presented in the first cycle after reset.
    pulse_frame(32'hBA45FF00);
    check("press_n1_valid", 32'(bus.out_valid), 32'd0);
    wait_n(1);
    check("press_n2_valid", 32'(bus.out_valid), 32'd1);
    check("press_n2_data",  32'(bus.out_data),  32'h145);
    check("press_n2_down",  32'(bus.key_down),  32'd1);
    wait_n(11);
    check("hold_n13_down",  32'(bus.key_down),  32'd1);
    wait_n(1);
    check("rel_n14_valid",  32'(bus.out_valid), 32'd1);
    check("rel_n14_data",   32'(bus.out_data),  32'h045);
    check("rel_n14_down",   32'(bus.key_down),  32'd0);
    wait_n(3);

    // Repeat codes keep the key held without extra events.
    pulse_frame(32'hBA45FF00);
    wait_n(3);
    repeat (5) begin
      wait_n(7);
      pulse_repeat();
    end
    check("rep_no_event", 32'(bus.out_valid), 32'd0);
    check("rep_down",     32'(bus.key_down),  32'd1);
    wait_n(12);
    check("rep_r13_down", 32'(bus.key_down),  32'd1);
    wait_n(1);
    check("rep_rel_data", 32'(bus.out_data),  32'h045);
    check("rep_rel_down", 32'(bus.key_down),  32'd0);
    wait_n(3);

    // Key swap: release and new press on consecutive cycles.
    pulse_frame(32'hBA45FF00);
    wait_n(3);
    pulse_frame(32'hF30CFF00);
    wait_n(1);
    check("swap_rel_valid", 32'(bus.out_valid), 32'd1);
    check("swap_rel_data",  32'(bus.out_data),  32'h045);
    wait_n(1);
    check("swap_prs_valid", 32'(bus.out_valid), 32'd1);
    check("swap_prs_data",  32'(bus.out_data),  32'h10C);
    check("swap_key_code",  32'(bus.key_code),  32'h0C);
    wait_n(16);

    // Rejected frames and counter saturation.
    do_reset();
    pulse_frame(32'hBA44FF00);
    pulse_frame(32'hBA45FE01);
    wait_n(2);
    check("bad_err2",     32'(bus.err_count), 32'd2);
    check("bad_no_event", 32'(bus.out_valid), 32'd0);
    check("bad_no_key",   32'(bus.key_down),  32'd0);
    repeat (300) pulse_frame(32'hBA44FF00);
    wait_n(2);
    check("bad_sat", 32'(bus.err_count), 32'd255);

    // FIFO overflow: five events into four slots, then drain.
    do_reset();
    bus.out_ready = 1'b0;
    pulse_frame(nec(8'h00, 8'h21));
    wait_n(2);
    pulse_frame(nec(8'h00, 8'h22));
    wait_n(3);
    pulse_frame(nec(8'h00, 8'h23));
    wait_n(3);
    check("ovf_flag",  32'(bus.overflow),  32'd1);
    check("ovf_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    drain_exp[0] = 9'h121;
    drain_exp[1] = 9'h021;
    drain_exp[2] = 9'h122;
    drain_exp[3] = 9'h022;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_%0d", i), 32'(bus.out_data), 32'(drain_exp[i]));
      wait_n(1);
    end
    check("drain_empty", 32'(bus.out_valid), 32'd0);
    wait_n(20);

    // Reset while swapping: outputs clear at once, nothing emitted afterwards.
    do_reset();
    pulse_frame(nec(8'h00, 8'h31));
    wait_n(3);
    pulse_frame(nec(8'h00, 8'h32));
    wait_n(1);
    check("swap_pending", 32'(bus.key_down), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_swap");
    wait_n(1);
    rst_n = 1'b1;
    wait_n(20);
    check("rst_after_valid", 32'(bus.out_valid), 32'd0);
    check("rst_after_down",  32'(bus.key_down),  32'd0);

    // Randomized traffic with varying density and backpressure.
    do_reset();
    for (int blk = 0; blk < 12; blk++) begin
      int dens;
      int rdy;
      dens = int'($urandom_range(0, 3));
      rdy  = int'($urandom_range(0, 3));
      if (blk == 6) do_reset();
      for (int k = 0; k < 250; k++) begin
        logic [7:0] c;
        int corr;
        c    = 8'h10 + 8'($urandom_range(0, 3));
        corr = int'($urandom_range(0, 7));
        bus.frame_valid  = (dens > 0) && ($urandom_range(0, 12 - 3 * dens) == 0);
        bus.repeat_valid = (dens > 0) && ($urandom_range(0, 9) == 0);
        bus.out_ready    = (rdy == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
        if (corr == 0)      bus.frame = {c, c, 8'hFF, 8'h00};
        else if (corr == 1) bus.frame = {~c, c, 8'hFE, 8'h01};
        else                bus.frame = nec(8'h00, c);
        @(negedge clk);
      end
    end
    bus.frame_valid  = 1'b0;
    bus.repeat_valid = 1'b0;
    bus.out_ready    = 1'b1;
    wait_n(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
